// File: rtl/uart_tx_fifo_if.sv
// Handshake bundle between the terminal buffer and the UART TX stage.
// master: byte/strobe/clear driver; slave: the TX FIFO (line and status out).
interface uart_tx_fifo_if;
    logic [7:0] i_data;
    logic       i_data_v;
    logic       i_overflow_clr;
    logic       o_tx;
    logic       o_busy;
    logic       o_full;
    logic       o_empty;
    logic       o_overflow;

    modport master (
        output i_data, i_data_v, i_overflow_clr,
        input  o_tx, o_busy, o_full, o_empty, o_overflow
    );

    modport slave (
        input  i_data, i_data_v, i_overflow_clr,
        output o_tx, o_busy, o_full, o_empty, o_overflow
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding an 8N1 UART transmitter (8E1 with UART_TX_PARITY_EN).
// Ports: clk, rst (async high), bus (slave): i_data/i_data_v/i_overflow_clr
// in; o_tx, o_busy, o_full, o_empty, o_overflow out.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 217,
    parameter int FIFO_AW      = 4
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_fifo_if.slave bus
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_AW:0] CNT_ONE = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] rd_ptr, wr_ptr;
    logic [FIFO_AW:0]   count;
    logic               full, empty;
    logic               push, pop, drop;
    logic               ovf_q;
    logic [7:0]         head;

    state_t      state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        baud_done;
`ifdef UART_TX_PARITY_EN
    logic        par_q, par_d;
`endif

    // count never exceeds DEPTH, so its MSB alone marks full
    assign full  = count[FIFO_AW];
    assign empty = (count == '0);
    assign push  = bus.i_data_v & ~full;
    assign drop  = bus.i_data_v & full;
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.i_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !pop) begin
                count <= count + CNT_ONE;
            end else if (pop && !push) begin
                count <= count - CNT_ONE;
            end
            // a drop in the same cycle as a clear keeps the flag set
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (bus.i_overflow_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign baud_done = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + 16'd1;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            IDLE: begin
                baud_d = '0;
                tx_d   = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    tx_d    = 1'b0;
                    state_d = START;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^head;
`endif
                end
            end
            START: begin
                if (baud_done) begin
                    baud_d  = '0;
                    tx_d    = shift_q[0];
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = par_q;
                        state_d = PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = STOP;
`endif
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                        bit_d   = bit_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_done) begin
                    baud_d  = '0;
                    tx_d    = 1'b1;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (baud_done) begin
                    baud_d = '0;
                    // chain straight into the next start bit when queued
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = head;
                        tx_d    = 1'b0;
                        state_d = START;
`ifdef UART_TX_PARITY_EN
                        par_d   = ^head;
`endif
                    end else begin
                        tx_d    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign bus.o_tx       = tx_q;
    assign bus.o_full     = full;
    assign bus.o_empty    = empty;
    assign bus.o_overflow = ovf_q;
    assign bus.o_busy     = (state_q != IDLE) | ~empty;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo with CLKS_PER_BIT=4, FIFO_AW=4.
// Cycle-exact line checks, burst/overflow, clear priority and reset abort.
module tb_uart_tx_fifo;
    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    uart_tx_fifo_if bus();

    uart_tx_fifo #(
        .CLKS_PER_BIT(CPB),
        .FIFO_AW(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic [9:0] line;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [7:0] d);
        bus.i_data   = d;
        bus.i_data_v = 1'b1;
        tick();
        bus.i_data_v = 1'b0;
    endtask

    // Called one cycle-slot before the start bit's edge; checks every clock.
    task automatic expect_line(input logic [9:0] pat, input string nm);
        logic [10:0] seq;
        int          nb;
`ifdef UART_TX_PARITY_EN
        seq = {pat[9], ^pat[8:1], pat[8:0]};
        nb  = 11;
`else
        seq = {1'b0, pat};
        nb  = 10;
`endif
        for (int b = 0; b < nb; b++) begin
            logic act;
            logic bsy;
            act = seq[b];
            bsy = 1'b1;
            repeat (CPB) begin
                tick();
                if (bus.o_tx !== seq[b]) act = bus.o_tx;
                if (bus.o_busy !== 1'b1) bsy = 1'b0;
            end
            chk($sformatf("%s bit%0d tx/busy", nm, b),
                {30'd0, bsy, act}, {30'd0, 1'b1, seq[b]});
        end
    endtask

    task automatic expect_idle(input int n, input string nm);
        int bad;
        bad = 0;
        repeat (n) begin
            tick();
            if (bus.o_tx !== 1'b1 || bus.o_busy !== 1'b0 ||
                bus.o_empty !== 1'b1)
                bad++;
        end
        chk(nm, bad, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{8'h41, 10'b1010000010};
        vecs[1] = '{8'h6A, 10'b1011010100};
        vecs[2] = '{8'h6B, 10'b1011010110};
        vecs[3] = '{8'h6C, 10'b1011011000};
        vecs[4] = '{8'h00, 10'b1000000000};
        vecs[5] = '{8'hFF, 10'b1111111110};
        vecs[6] = '{8'hA5, 10'b1101001010};
        vecs[7] = '{8'h07, 10'b1000001110};

        rst                = 1'b1;
        bus.i_data         = 8'h00;
        bus.i_data_v       = 1'b0;
        bus.i_overflow_clr = 1'b0;
        #1;
        chk("rst_tx", bus.o_tx, 1);
        chk("rst_empty", bus.o_empty, 1);
        chk("rst_full", bus.o_full, 0);
        chk("rst_busy", bus.o_busy, 0);
        chk("rst_ovf", bus.o_overflow, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        // single frames from the table
        for (int i = 0; i < 8; i++) begin
            write(vecs[i].data);
            chk($sformatf("v%0d tx_before_start", i), bus.o_tx, 1);
            expect_line(vecs[i].line, $sformatf("v%0d", i));
            chk($sformatf("v%0d busy_last", i), bus.o_busy, 1);
            chk($sformatf("v%0d empty", i), bus.o_empty, 1);
            tick();
            chk($sformatf("v%0d busy_fall", i), bus.o_busy, 0);
            chk($sformatf("v%0d tx_idle", i), bus.o_tx, 1);
            tick();
        end

        // back-to-back frames with no idle gap
        fork
            begin
                write(vecs[1].data);
                write(vecs[2].data);
                write(vecs[3].data);
            end
            begin
                @(posedge clk);
                #1;
                for (int i = 1; i < 4; i++)
                    expect_line(vecs[i].line, $sformatf("b2b%0d", i));
            end
        join
        chk("b2b busy_last", bus.o_busy, 1);
        tick();
        chk("b2b busy_fall", bus.o_busy, 0);
        tick();

        // 20 writes every other clock: 17 accepted, 3 dropped
        fork
            begin
                for (int k = 0; k < 20; k++) begin
                    if (k == 19) bus.i_overflow_clr = 1'b1;
                    write(8'(8'h10 + k));
                    if (k == 15) chk("burst full_at_15", bus.o_full, 0);
                    if (k == 16) begin
                        chk("burst full_at_16", bus.o_full, 1);
                        chk("burst ovf_at_16", bus.o_overflow, 0);
                    end
                    if (k == 17) chk("burst ovf_drop", bus.o_overflow, 1);
                    if (k == 19) begin
                        chk("ovf clr_with_drop", bus.o_overflow, 1);
                        tick();
                        chk("ovf clr_alone", bus.o_overflow, 0);
                        bus.i_overflow_clr = 1'b0;
                    end else begin
                        tick();
                    end
                end
            end
            begin
                @(posedge clk);
                #1;
                for (int f = 0; f < 17; f++)
                    expect_line({1'b1, 8'(8'h10 + f), 1'b0},
                                $sformatf("burst%0d", f));
            end
        join
        expect_idle(30, "burst no_extra_frames");

        // reset in the middle of the data bits of 0x00, 5 bytes queued
        write(8'h00);
        for (int k = 0; k < 5; k++) write(8'(8'hC0 + k));
        repeat (10) tick();
        chk("mid_frame tx_low", bus.o_tx, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst tx", bus.o_tx, 1);
        chk("async_rst empty", bus.o_empty, 1);
        chk("async_rst busy", bus.o_busy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        expect_idle(60, "post_rst quiet");

        write(8'h5A);
        expect_line({1'b1, 8'h5A, 1'b0}, "post_rst");
        tick();
        chk("post_rst busy_fall", bus.o_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
